// File: rtl/my_fsm_pkg.sv
// Shared constants, state names and the fallback-table builder for the serial
// pattern detector.
package fsm_pkg;

    localparam int PATTERN_LEN = 3;
    localparam logic [PATTERN_LEN-1:0] PATTERN = 3'b101;
    localparam int STATE_W = $clog2(PATTERN_LEN);

    // State value = length of the matched pattern prefix.
    typedef enum logic [STATE_W-1:0] {
        S0  = 2'd0,
        S1  = 2'd1,
        S10 = 2'd2
    } state_t;

    // Next state from prefix length k on bit b: the longest proper prefix of the
    // pattern that is a suffix of (prefix(k), b). Pattern bit i (i=0 first
    // received) is pat[len-1-i].
    function automatic int fallback_next(input logic [31:0] pat, input int len,
                                         input int k, input logic b);
        int  best;
        int  j_max;
        bit  ok;
        logic s_bit;
        best  = 0;
        j_max = (k + 1 < len - 1) ? k + 1 : len - 1;
        for (int j = j_max; j >= 1; j--) begin
            if (best == 0) begin
                ok = 1'b1;
                for (int t = 0; t < j; t++) begin
                    s_bit = ((k + 1 - j + t) == k) ? b : pat[len - 1 - (k + 1 - j + t)];
                    if (s_bit != pat[len - 1 - t]) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/my_fsm.sv
// Serial pattern detector: Mealy strobe on the bit that completes PATTERN,
// overlapping matches allowed, synchronous active-high reset.
module my_fsm
    import fsm_pkg::*;
#(
    parameter int PATTERN_LEN = fsm_pkg::PATTERN_LEN,
    parameter logic [PATTERN_LEN-1:0] PATTERN = fsm_pkg::PATTERN
) (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic out
);

    localparam int SW = $clog2(PATTERN_LEN);

    logic [SW-1:0] state;
    logic [SW-1:0] next_state;

    // Transition ROM indexed by {state, in}; unreachable encodings map to S0.
    logic [SW-1:0] next_tbl [2**(SW+1)];

    for (genvar g = 0; g < 2**SW; g++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam int NX = (g < PATTERN_LEN)
                ? fallback_next(32'(PATTERN), PATTERN_LEN, g, 1'(b)) : 0;
            assign next_tbl[g*2 + b] = SW'(NX);
        end
    end

    always_comb begin
        next_state = next_tbl[{state, in}];
        out = (state == SW'(PATTERN_LEN - 1)) && (in == PATTERN[0]) && !reset;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= '0;
        else       state <= next_state;
    end

endmodule

// File: tb/tb_my_fsm.sv
// Self-checking bench for my_fsm: directed vector table plus random bits
// compared against a received-history reference model.
module tb_my_fsm;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in    = 1'b0;
    logic out;

    int vectors     = 0;
    int miscompares = 0;

    my_fsm dut (.clock(clock), .reset(reset), .in(in), .out(out));

    always #5 clock = ~clock;

    typedef struct {
        logic r;
        logic b;
        logic exp;
        string name;
    } vec_t;

    vec_t tbl[$];

    task automatic apply(input logic r, input logic b, input logic exp, input string name);
        reset = r;
        in    = b;
        @(negedge clock);
        vectors++;
        if (out !== exp) begin
            miscompares++;
            $display("FAIL %s #%0d: out=%b expected=%b (reset=%b in=%b)",
                     name, vectors, out, exp, r, b);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic r, input logic b, input logic exp, input string name);
        vec_t v;
        v.r = r; v.b = b; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    // Reference model: bits received since the last reset.
    logic [2:0] hist;
    int         cnt;

    initial begin
        // reset held two edges with in=1
        add(1, 1, 0, "reset_hold"); add(1, 1, 0, "reset_hold");
        // basic 0,1,0,1
        add(0, 0, 0, "basic"); add(0, 1, 0, "basic");
        add(0, 0, 0, "basic"); add(0, 1, 1, "basic");
        // overlap 1,0,1,0,1
        add(1, 0, 0, "reset"); 
        add(0, 1, 0, "overlap"); add(0, 0, 0, "overlap"); add(0, 1, 1, "overlap");
        add(0, 0, 0, "overlap"); add(0, 1, 1, "overlap");
        // non-match 1,1,0,0,1 then 1,0,0,1
        add(1, 0, 0, "reset");
        add(0, 1, 0, "nomatch"); add(0, 1, 0, "nomatch"); add(0, 0, 0, "nomatch");
        add(0, 0, 0, "nomatch"); add(0, 1, 0, "nomatch");
        add(0, 1, 0, "nomatch2"); add(0, 0, 0, "nomatch2");
        add(0, 0, 0, "nomatch2"); add(0, 1, 0, "nomatch2");
        // reset mid-match: 1,0, reset with in=1, then 1, 0, 1
        add(1, 0, 0, "reset");
        add(0, 1, 0, "midreset"); add(0, 0, 0, "midreset");
        add(1, 1, 0, "midreset_rst");
        add(0, 1, 0, "midreset"); add(0, 0, 0, "midreset"); add(0, 1, 1, "midreset");

        #1;
        foreach (tbl[i]) apply(tbl[i].r, tbl[i].b, tbl[i].exp, tbl[i].name);

        // Random stress with occasional resets
        hist = '0;
        cnt  = 0;
        apply(1, 0, 0, "rand_init");
        for (int i = 0; i < 1000; i++) begin
            logic r, b, exp;
            r   = ($urandom_range(0, 39) == 0);
            b   = 1'($urandom_range(0, 1));
            exp = !r && (cnt >= 2) && ({hist[1:0], b} == 3'b101);
            apply(r, b, exp, "random");
            if (r) begin
                hist = '0;
                cnt  = 0;
            end else begin
                hist = {hist[1:0], b};
                if (cnt < 3) cnt++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
